// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and data requesters.
// Data has priority; a saturating starvation counter forces fetch through after STARVE_MAX denials.
module mem_arb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic [3:0]        be,
  input  logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt_r;
  owner_t     rd_owner_r;
  logic       i_rvalid_r;
  logic       d_rvalid_r;
  logic       i_gnt_s;
  logic       d_gnt_s;

  // Grant selection: a starved fetch beats data, otherwise data beats fetch.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (rst) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (i_req && (starve_cnt_r == STARVE_LIM)) begin
      i_gnt_s = 1'b1;
    end else if (d_req) begin
      d_gnt_s = 1'b1;
    end else if (i_req) begin
      i_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Memory port mux driven by the winning requester.
  always_comb begin
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    be    = 4'b0000;
    if (d_gnt_s) begin
      addr  = d_addr;
      wdata = d_wdata;
      we    = d_we;
      be    = d_we ? d_be : 4'b1111;
    end else if (i_gnt_s) begin
      addr  = i_addr;
      wdata = '0;
      we    = 1'b0;
      be    = 4'b1111;
    end else begin
      addr  = '0;
      wdata = '0;
      we    = 1'b0;
      be    = 4'b0000;
    end
  end

  // Starvation counter, read-ownership tracking and response valid flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 8'd0;
      rd_owner_r   <= OWN_NONE;
      i_rvalid_r   <= 1'b0;
      d_rvalid_r   <= 1'b0;
    end else begin
      if (i_gnt_s || !i_req) begin
        starve_cnt_r <= 8'd0;
      end else if (starve_cnt_r < STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + 8'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
      if (i_gnt_s) begin
        rd_owner_r <= OWN_I;
        i_rvalid_r <= 1'b1;
        d_rvalid_r <= 1'b0;
      end else if (d_gnt_s && !d_we) begin
        rd_owner_r <= OWN_D;
        i_rvalid_r <= 1'b0;
        d_rvalid_r <= 1'b1;
      end else begin
        rd_owner_r <= OWN_NONE;
        i_rvalid_r <= 1'b0;
        d_rvalid_r <= 1'b0;
      end
    end
  end

  assign i_gnt = i_gnt_s;
  assign d_gnt = d_gnt_s;
  // A killed fetch or a reset in the response cycle swallows the in-flight response.
  assign i_rvalid = i_rvalid_r && (rd_owner_r == OWN_I) && !i_kill && !rst;
  assign d_rvalid = d_rvalid_r && !rst;
  assign i_rdata  = rdata;
  assign d_rdata  = rdata;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed plan items followed by constrained-random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_mem_arb;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst, i_req, i_kill, d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] i_addr, d_addr, d_wdata, rdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, we;
  logic [31:0] i_rdata, d_rdata, addr, wdata;
  logic [3:0]  be;

  int total = 0;
  int bad   = 0;
  int m_wait = 0;   // consecutive cycles fetch has been refused
  int m_pend = 0;   // 0 none, 1 fetch read in flight, 2 load in flight
  logic e_ig = 1'b0, e_dg = 1'b0;
  logic o_ig, o_dg, o_ir, o_dr, o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_ird;

  mem_arb #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .addr(addr), .wdata(wdata), .we(we), .be(be), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare all outputs with the model, then advance the model.
  task automatic step();
    logic [31:0] ea, ew;
    logic        ewe, eir, edr;
    logic [3:0]  ebe;
    #1;
    e_ig = 1'b0;
    e_dg = 1'b0;
    if (!rst) begin
      if (i_req && m_wait == STARVE) e_ig = 1'b1;
      else if (d_req)                e_dg = 1'b1;
      else if (i_req)                e_ig = 1'b1;
    end
    ea = 32'd0; ew = 32'd0; ewe = 1'b0; ebe = 4'd0;
    if (e_dg) begin
      ea = d_addr; ew = d_wdata; ewe = d_we; ebe = d_we ? d_be : 4'hF;
    end else if (e_ig) begin
      ea = i_addr; ebe = 4'hF;
    end
    eir = (m_pend == 1) && !i_kill && !rst;
    edr = (m_pend == 2) && !rst;
    o_ig = i_gnt; o_dg = d_gnt; o_ir = i_rvalid; o_dr = d_rvalid;
    o_we = we; o_be = be; o_addr = addr; o_ird = i_rdata;
    chk("i_gnt", i_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("addr", addr, ea);
    chk("wdata", wdata, ew);
    chk("we", we, ewe);
    chk("be", be, ebe);
    chk("i_rvalid", i_rvalid, eir);
    chk("d_rvalid", d_rvalid, edr);
    chk("i_rdata", i_rdata, rdata);
    chk("d_rdata", d_rdata, rdata);
    @(posedge clk);
    if (rst) begin
      m_wait = 0;
      m_pend = 0;
    end else begin
      if (e_ig || !i_req)     m_wait = 0;
      else if (m_wait < STARVE) m_wait++;
      m_pend = e_ig ? 1 : ((e_dg && !d_we) ? 2 : 0);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b1; i_kill = 1'b0; d_req = 1'b1; d_we = 1'b0;
    d_be = 4'h0; i_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h0; rdata = 32'h0;

    // Reset with both requests asserted
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_ig", o_ig, 1'b0);
      chk("rst_dg", o_dg, 1'b0);
      chk("rst_be", o_be, 4'h0);
      chk("rst_we", o_we, 1'b0);
    end
    rst = 1'b0;
    step();
    chk("first_dg", o_dg, 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    step();
    step();

    // Lone fetch
    i_req = 1'b1; i_addr = 32'h100;
    step();
    chk("lone_gnt", o_ig, 1'b1);
    chk("lone_addr", o_addr, 32'h100);
    i_req = 1'b0; rdata = 32'hDEADBEEF;
    step();
    chk("lone_rv", o_ir, 1'b1);
    chk("lone_rdata", o_ird, 32'hDEADBEEF);

    // Store beats fetch
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_be = 4'b0011; d_wdata = 32'h1234;
    i_req = 1'b1; i_addr = 32'h104;
    step();
    chk("st_dg", o_dg, 1'b1);
    chk("st_we", o_we, 1'b1);
    chk("st_be", o_be, 4'b0011);
    d_req = 1'b0; d_we = 1'b0;
    step();
    chk("st_no_drv", o_dr, 1'b0);
    chk("st_then_ig", o_ig, 1'b1);
    i_req = 1'b0;
    step();

    // Starvation: continuous loads with fetch pending
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; i_req = 1'b1; i_addr = 32'h108;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("starve_ig_c%0d", c), o_ig, (c == 5) ? 1'b1 : 1'b0);
      chk($sformatf("starve_dg_c%0d", c), o_dg, (c == 5) ? 1'b0 : 1'b1);
      if (c == 5) i_req = 1'b0;
    end
    d_req = 1'b0; i_req = 1'b0;
    step();

    // Kill of an in-flight fetch, with a load granted alongside
    i_req = 1'b1; i_addr = 32'h10C;
    step();
    i_req = 1'b0; i_kill = 1'b1; d_req = 1'b1; d_addr = 32'h400;
    step();
    chk("kill_irv", o_ir, 1'b0);
    chk("kill_dg", o_dg, 1'b1);
    i_kill = 1'b0; d_req = 1'b0;
    step();
    chk("kill_drv", o_dr, 1'b1);

    // Kill coincident with a fresh grant leaves that grant's response intact
    i_req = 1'b1; i_kill = 1'b1; i_addr = 32'h110;
    step();
    i_req = 1'b0; i_kill = 1'b0;
    step();
    chk("kill_same_cyc_rv", o_ir, 1'b1);

    // Reset mid-read, then the starvation count restarts from zero
    d_req = 1'b1; d_addr = 32'h500;
    step();
    d_req = 1'b0; rst = 1'b1;
    step();
    chk("rst_mid_drv", o_dr, 1'b0);
    rst = 1'b0; d_req = 1'b1; i_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("rst_cnt_ig_c%0d", c), o_ig, (c == 5) ? 1'b1 : 1'b0);
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Random traffic; requesters hold their inputs until granted
    for (int n = 0; n < 500; n++) begin
      if (!(i_req && !e_ig)) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = $urandom;
      end
      if (!(d_req && !e_dg)) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      i_kill = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 49) == 0);
      rdata  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter between the core's instruction-fetch and data (load/store) requesters. It drives the core's one memory interface (addr, wdata, we, be, rdata) and gives data accesses priority, with a starvation counter that guarantees forward progress of fetch. It tracks which requester owns the read in flight, routes the synchronous-memory response back one cycle later, and supports killing a pending fetch response on a control-flow change.

## Interface
- DATA_W, default 32: data width; equals the core register length.
- ADDR_W, default 32: address width.
- STARVE_MAX, default 4: number of consecutive denied fetch cycles after which fetch wins. Legal range is 1..255.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_kill  in  1  discard the fetch response currently in flight.
- i_gnt  out  1  fetch granted this cycle; combinational.
- i_rvalid  out  1  fetch data valid on i_rdata; registered.
- i_rdata  out  DATA_W  equal to rdata.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data granted this cycle; combinational.
- d_rvalid  out  1  load data valid on d_rdata; registered.
- d_rdata  out  DATA_W  equal to rdata.
- addr  out  ADDR_W  memory address.
- wdata  out  DATA_W  memory write data.
- we  out  1  memory write enable.
- be  out  4  memory byte enables.
- rdata  in  DATA_W  memory read data, valid the cycle after the address is presented.

## Operation
- **Registered state**
  - starve_cnt: 8 bits, saturating.
  - rd_owner: NONE, I or D.
  - i_rvalid and d_rvalid flops.
- **Grant rule** (combinational, evaluated every cycle; at most one grant per cycle):
  - If rst is high: no grant.
  - Else if i_req and starve_cnt == STARVE_MAX: i_gnt.
  - Else if d_req: d_gnt.
  - Else if i_req: i_gnt.
- **Memory drive**
  - On d_gnt: addr = d_addr, wdata = d_wdata, we = d_we, be = d_we ? d_be : 4'b1111.
  - On i_gnt: addr = i_addr, we = 0, be = 4'b1111, wdata = 0.
  - No grant: addr = 0, wdata = 0, we = 0, be = 0.
- **Starvation counter** (next state):
  - i_gnt or !i_req: cleared to 0.
  - i_req && !i_gnt: incremented, saturating at STARVE_MAX.
- **Ownership** (next rd_owner):
  - I on i_gnt.
  - D on d_gnt && !d_we.
  - NONE otherwise.
- **Responses**
  - d_rvalid next = (rd_owner next == D).
  - i_rvalid next = (rd_owner next == I).
  - Stores produce no rvalid; a store completes at its d_gnt cycle.
- **Kill**
  - i_kill applies only to a fetch response already in flight.
  - When i_kill is high in a cycle where rd_owner == I, i_rvalid is forced to 0 in that same cycle (gated output), and the response is dropped.
  - i_kill has no effect on d_rvalid.
  - i_kill in the same cycle as i_gnt does not suppress that new grant's response.
- **Reset**
  - starve_cnt = 0, rd_owner = NONE, i_rvalid = 0, d_rvalid = 0.
  - Memory outputs: addr = 0, wdata = 0, we = 0, be = 0.
  - Reset asserted mid-operation drops any in-flight response: no rvalid in the cycle after reset.

## Timing
- Grant latency is 0 cycles: gnt is asserted combinationally in the cycle of req.
- Read latency is exactly 1 cycle: rvalid is high the cycle after gnt, with rdata passed through unregistered.
- Back-to-back grants are allowed every cycle. Throughput is 1 access per cycle.
- A request whose address or data changes before gnt is undefined; requesters hold all inputs until gnt.
- Worst-case fetch wait under continuous d_req is STARVE_MAX cycles. Fetch is granted in cycle STARVE_MAX+1 of its request.
- Simultaneous i_req and d_req with starve_cnt < STARVE_MAX: data wins, and starve_cnt increments.

## Test plan
- Reset: hold rst for 2 cycles with both reqs high -> no gnt, we = 0, be = 0, both rvalid = 0; the first grant comes in the cycle after rst falls.
- Lone fetch: i_req with i_addr = 0x100, memory returns 0xDEADBEEF -> i_gnt in the same cycle, addr = 0x100, i_rvalid and i_rdata = 0xDEADBEEF in the next cycle.
- Store vs fetch: d_req store, d_addr = 0x200, d_be = 4'b0011, d_wdata = 0x1234, with i_req high -> d_gnt, we = 1, be = 4'b0011; no d_rvalid in the next cycle; i_gnt in the next cycle.
- Starvation: d_req held continuously (loads) with i_req high and STARVE_MAX = 4 -> d_gnt in cycles 1-4, i_gnt in cycle 5, d_gnt resumes in cycle 6.
- Kill: i_gnt in cycle N, i_kill high in cycle N+1 -> i_rvalid = 0 in N+1; a d_gnt load in N+1 still yields d_rvalid in N+2.
- Reset mid-read: d_gnt load in cycle N, rst high in N+1 -> d_rvalid = 0 in N+1, starve_cnt = 0.
